dmem_arbiter: RTL and testbench

Shares the single data-memory port (read address, write address/data/enable, read data) between two requesters: port 0 is the CPU data port, port 1 is a loader/debug master. Port 0 has priority, but a streak counter bounds consecutive port-0 grants while port 1 waits. A lock lets port 1 hold the memory for bursts. Read data is routed back to the originating requester one cycle after grant. The block sits between `cpu`/loader and `memory` in the test system.

---
 rtl/f8_mem_pkg.sv | 10 +
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/f8_mem_pkg.sv
// Shared data-memory definitions: default bus widths and requester identifiers.
package f8_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_t;
endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU priority bounded by a streak limit,
// loader lock for bursts, one-cycle read return routed to the requester that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W   = f8_mem_pkg::ADDR_W,
  parameter int DATA_W   = f8_mem_pkg::DATA_W,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] dread_addr,
  output logic [ADDR_W-1:0] dwrite_addr,
  output logic [DATA_W-1:0] dwrite_data,
  output logic              dwrite_en,
  input  logic [DATA_W-1:0] dread_data
);
  import f8_mem_pkg::*;

  localparam int STREAK_W = $clog2(HOLD_MAX + 1);
  localparam logic [STREAK_W-1:0] HOLD_LIM = STREAK_W'(HOLD_MAX);

  logic [STREAK_W-1:0] streak;
  logic                owner_locked;
  logic                rd_pend;
  port_t               rd_port;

  // Grants are suppressed while reset is held so no write can slip through.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (reset) begin
      if (owner_locked) begin
        p1_gnt = p1_req;
      end else if (p1_req && (!p0_req || streak == HOLD_LIM)) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    dread_addr  = '0;
    dwrite_addr = '0;
    dwrite_data = '0;
    dwrite_en   = 1'b0;
    if (p0_gnt) begin
      dread_addr  = p0_addr;
      dwrite_addr = p0_addr;
      dwrite_data = p0_wdata;
      dwrite_en   = p0_we;
    end else if (p1_gnt) begin
      dread_addr  = p1_addr;
      dwrite_addr = p1_addr;
      dwrite_data = p1_wdata;
      dwrite_en   = p1_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak       <= '0;
      owner_locked <= 1'b0;
      rd_pend      <= 1'b0;
      rd_port      <= PORT_CPU;
    end else begin
      // Streak only measures how long port 1 has been kept waiting.
      if (p1_gnt || !p1_req) begin
        streak <= '0;
      end else if (p0_gnt && streak != HOLD_LIM) begin
        streak <= streak + 1'b1;
      end

      if (!p1_lock) begin
        owner_locked <= 1'b0;
      end else if (p1_gnt) begin
        owner_locked <= 1'b1;
      end

      rd_pend <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
      rd_port <= p1_gnt ? PORT_AUX : PORT_CPU;
    end
  end

  assign p0_rvalid = rd_pend && (rd_port == PORT_CPU);
  assign p1_rvalid = rd_pend && (rd_port == PORT_AUX);
  assign p0_rdata  = p0_rvalid ? dread_data : '0;
  assign p1_rdata  = p1_rvalid ? dread_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model behind the shared port.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dwrite_en;
  logic [15:0] p0_rdata, p1_rdata, dread_addr, dwrite_addr, dwrite_data, dread_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dwrite_en) mem[dwrite_addr[7:0]] <= dwrite_data;
    dread_data <= mem[dread_addr[7:0]];
  end

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .dread_addr(dread_addr), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
    .dwrite_en(dwrite_en), .dread_data(dread_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    p1_lock = 1'b0;

    // Reset held with both requests high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
      check("rst_wen", 32'(dwrite_en), 32'd0);
      check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
      check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    end
    step();
    reset = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    check("idle_wen", 32'(dwrite_en), 32'd0);
    check("idle_raddr", 32'(dread_addr), 32'd0);

    // CPU write then read-back.
    step();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'h1234;
    @(negedge clk);
    check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
    check("wr_wen", 32'(dwrite_en), 32'd1);
    check("wr_waddr", 32'(dwrite_addr), 32'h0010);
    check("wr_wdata", 32'(dwrite_data), 32'h1234);
    step();
    p0_we = 1'b0;
    @(negedge clk);
    check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
    check("rd_wen", 32'(dwrite_en), 32'd0);
    check("rd_raddr", 32'(dread_addr), 32'h0010);
    check("rd_no_early_rvalid", 32'(p0_rvalid), 32'd0);
    step();
    p0_req = 1'b0;
    @(negedge clk);
    check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("rd_p0_rdata", 32'(p0_rdata), 32'h1234);
    check("rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rd_p1_rdata", 32'(p1_rdata), 32'd0);

    // Continuous contention: four CPU grants then one loader grant.
    step();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0001;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cont_p0_gnt", 32'(p0_gnt), (i % 5 < 4) ? 32'd1 : 32'd0);
      check("cont_p1_gnt", 32'(p1_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      check("cont_streak_bound", 32'(dut.streak <= 3'd4), 32'd1);
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // Locked burst of three loader writes, CPU waiting from the second on.
    step();
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 16'h0040; p1_wdata = 16'h0BEE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lock_p1_gnt", 32'(p1_gnt), 32'd1);
      check("lock_p0_gnt", 32'(p0_gnt), 32'd0);
      check("lock_waddr", 32'(dwrite_addr), 32'(16'h0040 + 16'(k)));
      step();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0003;
      p1_addr = 16'h0041 + 16'(k); p1_wdata = 16'h0BEF + 16'(k);
    end
    p1_req = 1'b0; p1_lock = 1'b0;
    @(negedge clk);
    check("unlock_p0_wait", 32'(p0_gnt), 32'd0);
    step();
    @(negedge clk);
    check("unlock_p0_gnt", 32'(p0_gnt), 32'd1);
    step();
    p0_req = 1'b0;

    // Preload two words through the arbiter.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0020; p0_wdata = 16'hA5A5;
    step();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0021; p1_wdata = 16'h5A5A;
    @(negedge clk);
    check("pre_p1_gnt", 32'(p1_gnt), 32'd1);
    step();

    // Alternating reads, one per cycle.
    p0_we = 1'b0; p0_addr = 16'h0020;
    p1_we = 1'b0; p1_addr = 16'h0021;
    for (int i = 0; i < 6; i++) begin
      p0_req = (i % 2 == 0);
      p1_req = (i % 2 == 1);
      @(negedge clk);
      check("alt_p0_gnt", 32'(p0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_p1_gnt", 32'(p1_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 0) begin
        check("alt_first_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("alt_first_p1_rvalid", 32'(p1_rvalid), 32'd0);
      end else if (i % 2 == 1) begin
        check("alt_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("alt_p0_rdata", 32'(p0_rdata), 32'hA5A5);
        check("alt_p1_quiet", 32'(p1_rvalid), 32'd0);
      end else begin
        check("alt_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("alt_p1_rdata", 32'(p1_rdata), 32'h5A5A);
        check("alt_p0_quiet", 32'(p0_rvalid), 32'd0);
      end
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    check("alt_last_p1_rvalid", 32'(p1_rvalid), 32'd1);
    check("alt_last_p1_rdata", 32'(p1_rdata), 32'h5A5A);

    // Reset lands while a locked loader read is in flight.
    step();
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 16'h0030; p1_wdata = 16'h7777;
    @(negedge clk);
    check("rr_lock_gnt", 32'(p1_gnt), 32'd1);
    step();
    p1_we = 1'b0; p1_addr = 16'h0021; p0_req = 1'b1;
    @(negedge clk);
    check("rr_read_p1_gnt", 32'(p1_gnt), 32'd1);
    check("rr_read_p0_gnt", 32'(p0_gnt), 32'd0);
    step();
    reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    @(negedge clk);
    check("rr_during_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rr_during_p1_rdata", 32'(p1_rdata), 32'd0);
    check("rr_during_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    step();
    reset = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0005;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0006;
    @(negedge clk);
    check("rr_after_p1_rvalid", 32'(p1_rvalid), 32'd0);
    check("rr_after_streak", 32'(dut.streak), 32'd0);
    check("rr_after_lock", 32'(dut.owner_locked), 32'd0);
    check("rr_after_p0_gnt", 32'(p0_gnt), 32'd1);
    check("rr_after_p1_gnt", 32'(p1_gnt), 32'd0);
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
